// File: rtl/vm_pkg.sv
// Shared constants for the vending machine input conditioner: button indices,
// debounce counter width and an item-event counting helper.
package vm_pkg;

  localparam int unsigned BTN_SHEKEL = 0;
  localparam int unsigned BTN_RET    = 1;
  localparam int unsigned BTN_JELLY  = 2;
  localparam int unsigned BTN_BUBBLY = 3;
  localparam int unsigned BTN_SOUR   = 4;
  localparam int unsigned BTN_COUNT  = 5;

  localparam int unsigned DB_CNT_W = 16;

  localparam logic [BTN_COUNT-1:0] ITEM_MASK = 5'b11100;

  typedef logic [BTN_COUNT-1:0] btn_vec_t;

  function automatic logic [1:0] item_count(btn_vec_t ev);
    return {1'b0, ev[BTN_JELLY]} + {1'b0, ev[BTN_BUBBLY]} + {1'b0, ev[BTN_SOUR]};
  endfunction

endpackage

// File: rtl/vm_debounce.sv
// One panel input channel: 2-flop synchroniser, debounce counter/state and a
// registered rising-edge event aligned with the registered exported level.
module vm_debounce
  import vm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  logic                sync1_q, sync2_q;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                state_q, state_d;
  logic                lvl_q, rise_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The exported level is a registered copy of the state so that the level and
  // the rising-edge event change on the same clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= 1'b0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      lvl_q   <= state_q;
      rise_q  <= state_q & ~lvl_q;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/vm_input_conditioner.sv
// Panel front end: five debounced channels, priority arbitration into single-cycle
// command pulses. Define VM_INPUT_LOCKOUT_EN to add the post-event lockout window.
module vm_input_conditioner
  import vm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 shekel_raw_i,
  input  logic                 ret_raw_i,
  input  logic                 jelly_raw_i,
  input  logic                 bubbly_raw_i,
  input  logic                 sour_raw_i,
  output logic                 shekel_p_o,
  output logic                 ret_p_o,
  output logic                 jelly_p_o,
  output logic                 bubbly_p_o,
  output logic                 sour_p_o,
  output logic [BTN_COUNT-1:0] btn_lvl_o,
  output logic                 conflict_p_o
);

  btn_vec_t raw, lvl, ev;
  btn_vec_t pulse_q, pulse_d;
  logic     conflict_q, conflict_d;
  logic     locked;

  assign raw = {sour_raw_i, bubbly_raw_i, jelly_raw_i, ret_raw_i, shekel_raw_i};

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_chan
    vm_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw_i  (raw[i]),
      .level_o(lvl[i]),
      .rise_o (ev[i])
    );
  end

  always_comb begin
    pulse_d    = '0;
    conflict_d = 1'b0;
    if (ev[BTN_RET]) begin
      pulse_d[BTN_RET] = 1'b1;
    end else if (!locked) begin
      unique case (item_count(ev))
        2'd0:    pulse_d[BTN_SHEKEL] = ev[BTN_SHEKEL];
        2'd1:    pulse_d = ev & ITEM_MASK;
        default: conflict_d = 1'b1;
      endcase
    end
  end

`ifdef VM_INPUT_LOCKOUT_EN
  logic [DB_CNT_W-1:0] lock_q, lock_d;

  assign locked = (lock_q != '0);

  always_comb begin
    lock_d = lock_q;
    if (pulse_d[BTN_RET]) begin
      lock_d = '0;
    end else if (|pulse_d) begin
      lock_d = DB_CNT_W'(LOCKOUT_CYCLES);
    end else if (locked) begin
      lock_d = lock_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pulse_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      pulse_q    <= pulse_d;
      conflict_q <= conflict_d;
    end
  end

  assign shekel_p_o   = pulse_q[BTN_SHEKEL];
  assign ret_p_o      = pulse_q[BTN_RET];
  assign jelly_p_o    = pulse_q[BTN_JELLY];
  assign bubbly_p_o   = pulse_q[BTN_BUBBLY];
  assign sour_p_o     = pulse_q[BTN_SOUR];
  assign conflict_p_o = conflict_q;
  assign btn_lvl_o    = lvl;

endmodule
